// File: rtl/parity_display_pkg.sv
// Shared segment encodings for the parity-checked 7-segment display.
// Bit order is {g,f,e,d,c,b,a}, active-high (1 = segment lit).
package parity_display_pkg;

    typedef logic [6:0] seg7_t;

    localparam seg7_t SEG_BLANK = 7'b0000000;
    localparam seg7_t SEG_DASH  = 7'b1000000;

    localparam seg7_t SEG_HEX_0 = 7'b0111111;
    localparam seg7_t SEG_HEX_1 = 7'b0000110;
    localparam seg7_t SEG_HEX_2 = 7'b1011011;
    localparam seg7_t SEG_HEX_3 = 7'b1001111;
    localparam seg7_t SEG_HEX_4 = 7'b1100110;
    localparam seg7_t SEG_HEX_5 = 7'b1101101;
    localparam seg7_t SEG_HEX_6 = 7'b1111101;
    localparam seg7_t SEG_HEX_7 = 7'b0000111;
    localparam seg7_t SEG_HEX_8 = 7'b1111111;
    localparam seg7_t SEG_HEX_9 = 7'b1101111;
    localparam seg7_t SEG_HEX_A = 7'b1110111;
    localparam seg7_t SEG_HEX_B = 7'b1111100;
    localparam seg7_t SEG_HEX_C = 7'b0111001;
    localparam seg7_t SEG_HEX_D = 7'b1011110;
    localparam seg7_t SEG_HEX_E = 7'b1111001;
    localparam seg7_t SEG_HEX_F = 7'b1110001;

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational nibble-to-glyph decoder for one 7-segment digit.
// Always produces the active-high encoding; polarity is handled by the top.
module hex_to_seg7
    import parity_display_pkg::*;
(
    input  logic [3:0] nibble,
    output seg7_t      seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (nibble)
            4'h0: seg = SEG_HEX_0;
            4'h1: seg = SEG_HEX_1;
            4'h2: seg = SEG_HEX_2;
            4'h3: seg = SEG_HEX_3;
            4'h4: seg = SEG_HEX_4;
            4'h5: seg = SEG_HEX_5;
            4'h6: seg = SEG_HEX_6;
            4'h7: seg = SEG_HEX_7;
            4'h8: seg = SEG_HEX_8;
            4'h9: seg = SEG_HEX_9;
            4'hA: seg = SEG_HEX_A;
            4'hB: seg = SEG_HEX_B;
            4'hC: seg = SEG_HEX_C;
            4'hD: seg = SEG_HEX_D;
            4'hE: seg = SEG_HEX_E;
            4'hF: seg = SEG_HEX_F;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/parity_display.sv
// Registered even-parity check and 7-segment decode of a 5-bit value.
// Define PARITY_DISPLAY_ACTIVE_LOW_EN to invert Segmentos for common-anode parts.
module parity_display
    import parity_display_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] Valores,
    input  logic       Paridade,
    output logic [6:0] Segmentos,
    output logic       Validade
);

    logic  word_ok;
    seg7_t glyph;
    seg7_t seg_high;
    seg7_t seg_drive;

    assign word_ok = ~^{Valores, Paridade};

    hex_to_seg7 u_hex_to_seg7 (
        .nibble (Valores[3:0]),
        .seg    (glyph)
    );

    // Values above 15 have no hex glyph, so they show a dash instead.
    always_comb begin
        seg_high = SEG_BLANK;
        if (word_ok) begin
            seg_high = Valores[4] ? SEG_DASH : glyph;
        end
    end

`ifdef PARITY_DISPLAY_ACTIVE_LOW_EN
    localparam seg7_t SEG_RESET = ~SEG_BLANK;
    assign seg_drive = ~seg_high;
`else
    localparam seg7_t SEG_RESET = SEG_BLANK;
    assign seg_drive = seg_high;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Segmentos <= SEG_RESET;
            Validade  <= 1'b0;
        end else begin
            Segmentos <= seg_drive;
            Validade  <= word_ok;
        end
    end

endmodule

// File: tb/tb_parity_display.sv
// Self-checking bench for parity_display using an expected-result queue.
// Honours PARITY_DISPLAY_ACTIVE_LOW_EN by inverting expected segment values.
module tb_parity_display;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [4:0] Valores = 5'd0;
    logic       Paridade = 1'b0;
    logic [6:0] Segmentos;
    logic       Validade;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [4:0] v;
        logic       p;
        logic [6:0] seg;
        logic       ok;
    } exp_t;

    exp_t sb[$];

`ifdef PARITY_DISPLAY_ACTIVE_LOW_EN
    localparam bit INV = 1'b1;
`else
    localparam bit INV = 1'b0;
`endif
    localparam logic [6:0] RST_SEG = INV ? 7'b1111111 : 7'b0000000;

    parity_display dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .Valores   (Valores),
        .Paridade  (Paridade),
        .Segmentos (Segmentos),
        .Validade  (Validade)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] glyph_of(input logic [3:0] n);
        case (n)
            4'd0:  return 7'b0111111;
            4'd1:  return 7'b0000110;
            4'd2:  return 7'b1011011;
            4'd3:  return 7'b1001111;
            4'd4:  return 7'b1100110;
            4'd5:  return 7'b1101101;
            4'd6:  return 7'b1111101;
            4'd7:  return 7'b0000111;
            4'd8:  return 7'b1111111;
            4'd9:  return 7'b1101111;
            4'd10: return 7'b1110111;
            4'd11: return 7'b1111100;
            4'd12: return 7'b0111001;
            4'd13: return 7'b1011110;
            4'd14: return 7'b1111001;
            default: return 7'b1110001;
        endcase
    endfunction

    function automatic exp_t model(input logic [4:0] v, input logic p);
        exp_t e;
        int   ones;
        ones = int'(p);
        for (int b = 0; b < 5; b++) ones += int'(v[b]);
        e.v  = v;
        e.p  = p;
        e.ok = (ones % 2) == 0;
        if (!e.ok)          e.seg = 7'b0000000;
        else if (v > 5'd15) e.seg = 7'b1000000;
        else                e.seg = glyph_of(v[3:0]);
        if (INV) e.seg = ~e.seg;
        return e;
    endfunction

    // Drive a word mid-cycle, queue its expectation, then pop it just after the capturing edge.
    task automatic step(input logic [4:0] v, input logic p, output exp_t e);
        @(negedge clk);
        Valores  = v;
        Paridade = p;
        sb.push_back(model(v, p));
        @(posedge clk);
        #1;
        e = sb.pop_front();
    endtask

    task automatic test_reset;
        #3;
        checks++;
        if (Segmentos !== RST_SEG || Validade !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold seg=%b val=%b want seg=%b val=0", Segmentos, Validade, RST_SEG);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (Segmentos !== RST_SEG || Validade !== 1'b0) begin
            errors++;
            $display("FAIL reset_release seg=%b val=%b want seg=%b val=0", Segmentos, Validade, RST_SEG);
        end
    endtask

    task automatic test_directed;
        logic [5:0] words [9];
        exp_t e;
        words = '{6'b00001_0, 6'b00001_1, 6'b00010_0, 6'b10101_0, 6'b10101_1,
                  6'b01111_0, 6'b10000_1, 6'b00000_0, 6'b11111_1};
        foreach (words[k]) begin
            step(words[k][5:1], words[k][0], e);
            checks++;
            if (Validade !== e.ok) begin
                errors++;
                $display("FAIL directed_valid v=%0d p=%0d got=%b want=%b", e.v, e.p, Validade, e.ok);
            end
            checks++;
            if (Segmentos !== e.seg) begin
                errors++;
                $display("FAIL directed_seg v=%0d p=%0d got=%b want=%b", e.v, e.p, Segmentos, e.seg);
            end
        end
    endtask

    task automatic test_sweep;
        exp_t e;
        logic [5:0] w;
        for (int i = 0; i < 64; i++) begin
            w = i[5:0];
            step(w[5:1], w[0], e);
            checks++;
            if (Validade !== e.ok || Segmentos !== e.seg) begin
                errors++;
                $display("FAIL sweep v=%0d p=%0d got seg=%b val=%b want seg=%b val=%b",
                         e.v, e.p, Segmentos, Validade, e.seg, e.ok);
            end
        end
    endtask

    task automatic test_stable;
        exp_t e;
        exp_t ref_e;
        step(5'd10, 1'b0, ref_e);
        for (int c = 0; c < 4; c++) begin
            step(5'd10, 1'b0, e);
            checks++;
            if (Segmentos !== ref_e.seg || Validade !== ref_e.ok) begin
                errors++;
                $display("FAIL stable cyc=%0d got seg=%b val=%b want seg=%b val=%b",
                         c, Segmentos, Validade, ref_e.seg, ref_e.ok);
            end
        end
    endtask

    task automatic test_reset_midstream;
        exp_t e;
        step(5'd1, 1'b1, e);
        checks++;
        if (Segmentos !== e.seg || Validade !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset got seg=%b val=%b want seg=%b val=1", Segmentos, Validade, e.seg);
        end
        // Queue the next word, then reset before its capturing edge so it is discarded.
        @(negedge clk);
        Valores  = 5'd3;
        Paridade = 1'b0;
        sb.push_back(model(5'd3, 1'b0));
        #2;
        rst_n = 1'b0;
        sb.delete();
        #1;
        checks++;
        if (Segmentos !== RST_SEG || Validade !== 1'b0) begin
            errors++;
            $display("FAIL async_reset got seg=%b val=%b want seg=%b val=0", Segmentos, Validade, RST_SEG);
        end
        @(posedge clk);
        #1;
        checks++;
        if (Segmentos !== RST_SEG || Validade !== 1'b0) begin
            errors++;
            $display("FAIL reset_over_edge got seg=%b val=%b want seg=%b val=0", Segmentos, Validade, RST_SEG);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step(5'd12, 1'b0, e);
        checks++;
        if (Segmentos !== e.seg || Validade !== e.ok) begin
            errors++;
            $display("FAIL post_reset got seg=%b val=%b want seg=%b val=%b", Segmentos, Validade, e.seg, e.ok);
        end
    endtask

    initial begin
        test_reset;
        test_directed;
        test_sweep;
        test_stable;
        test_reset_midstream;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

endmodule
